bit_scan_encoder: RTL and testbench
===================================

# bit_scan_encoder

Sequential set-bit enumerator: accepts a WORD_WIDTH-bit word over a valid/ready handshake and emits the binary index of every set bit, one per output beat, lowest index first. It is the encoding-side counterpart of tree_decoder: tree_decoder expands an index into a one-hot word, and this block turns a multi-hot word back into a stream of indices. It serves interrupt/request scanners and free-slot allocators in the std utility library.

## Interface
- WORD_WIDTH, 8, width of the scanned word (>= 2)
- INDEX_WIDTH, $clog2(WORD_WIDTH), width of the emitted index
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_word is offered
- in_ready  out  1  block can accept a word
- in_word  in  WORD_WIDTH  word to scan
- out_valid  out  1  out_index/out_last/out_empty are valid
- out_ready  in  1  consumer takes the current beat
- out_index  out  INDEX_WIDTH  index of the current set bit
- out_last  out  1  current beat is the final beat for this word
- out_empty  out  1  accepted word was all-zero (single marker beat)

## Operation
- FSM states: IDLE, SCAN (typedef in package).
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, register in_word into pending mask and go to SCAN.
- SCAN: in_ready=0, out_valid=1. out_index = encode(isolate-lowest-set-bit(pending)). out_last=1 when pending has exactly one set bit.
- Beat handshake (out_valid&&out_ready): clear the reported bit in pending. If out_last, return to IDLE.
- Zero word: accepted normally; SCAN emits one beat with out_empty=1, out_index=0, out_last=1. out_empty=0 on all other beats.
- out_ready low: all outputs and pending held unchanged (no index skipping, no glitching).
- in_valid while not ready: ignored, word not captured; upstream holds it.
- Reset (any time, including mid-scan): state=IDLE, pending=0, out_valid=0, out_index=0, out_last=0, out_empty=0, in_ready=1 in the cycle after reset is sampled. Beats pending at reset are discarded.
- Reset values of all outputs: in_ready=1, out_valid=0, out_index=0, out_last=0, out_empty=0.

## Timing
- Accept at edge N -> first beat valid from cycle N+1 (1-cycle latency).
- With out_ready held high, k set bits take k consecutive cycles; zero word takes 1.
- After the last-beat handshake at edge M, in_ready=1 in cycle M+1; next word earliest accepted at edge M+1 (no same-cycle overlap between words).
- out_index, out_last, out_empty are registered-state-derived; no combinational path from in_word or out_ready to out_* signals. in_ready depends on state only.

## Configuration
- BIT_SCAN_ENCODER_MSB_FIRST_EN defined: bits enumerated highest index first (isolate-highest-set-bit); out_last still marks the final beat.
- Not defined: lowest index first, as described above. Ports, latency and zero-word behaviour identical in both builds.

## Structure
- Package bit_scan_encoder_pkg: state enum typedef (IDLE, SCAN).
- Bit isolation reuses screening_by_junior (default) / screening_by_senior (MSB-first build).
- One natural sub-module: one_hot_encoder (combinational one-hot to binary index, parameterised by WORD_WIDTH).
- Single-bit detection (out_last): pending & (pending-1) == 0, computed inline.

## Test plan
- Reset, then idle 3 cycles -> in_ready=1, out_valid=0, out_index=0 throughout.
- in_word=8'b1010_0100, out_ready=1 -> beats 2,5,7 on consecutive cycles, out_last only on 7, in_ready=1 cycle after.
- in_word=8'h00 -> one beat out_empty=1, out_index=0, out_last=1; then IDLE.
- in_word=8'b1000_0001, out_ready low 3 cycles then high -> index 0 held stable for 4 cycles, then 7 with out_last=1.
- in_word=8'hFF with in_valid held high and new word 8'h02 offered -> indices 0..7, in_ready=0 throughout, 8'h02 accepted only after last beat, then index 1.
- reset asserted after first beat of 8'b0011_0000 -> out_valid=0 next cycle, index 5 never emitted; MSB-first build on 8'b1010_0100 -> 7,5,2.

Source files
------------

// File: rtl/bit_scan_encoder_pkg.sv
// Shared types for bit_scan_encoder: the two-state scan FSM encoding.
package bit_scan_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/bit_scan_encoder_one_hot_encoder.sv
// one_hot_encoder: combinational one-hot to binary index.
// An all-zero input yields index 0.
module one_hot_encoder #(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0]  one_hot,
  output logic [INDEX_WIDTH-1:0] index
);

  // OR together the positions of every set bit; with a one-hot input this is the bit's index
  always_comb begin
    index = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (one_hot[i]) index = index | INDEX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: accepts a word over valid/ready and emits the index of every
// set bit, one beat per set bit. An all-zero word yields one out_empty marker beat.
// Build option: BIT_SCAN_ENCODER_MSB_FIRST_EN enumerates highest index first.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; valid is never withdrawn by this block until its beat transfers, and all
// out_* signals hold steady while out_ready is low.
module bit_scan_encoder
  import bit_scan_encoder_pkg::*;
#(
  parameter int WORD_WIDTH  = 8,
  parameter int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_WIDTH-1:0]  in_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic                   out_last,
  output logic                   out_empty
);

  state_t                 state, state_next;
  logic [WORD_WIDTH-1:0]  pending, pending_next;
  logic [WORD_WIDTH-1:0]  isolated;
  logic [INDEX_WIDTH-1:0] enc_index;
  logic                   single_bit;

`ifdef BIT_SCAN_ENCODER_MSB_FIRST_EN
  // Keep only the highest set bit of v
  function automatic logic [WORD_WIDTH-1:0] screening_by_senior(input logic [WORD_WIDTH-1:0] v);
    logic [WORD_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  assign isolated = screening_by_senior(pending);
`else
  // Keep only the lowest set bit of v (two's-complement trick)
  function automatic logic [WORD_WIDTH-1:0] screening_by_junior(input logic [WORD_WIDTH-1:0] v);
    return v & (~v + WORD_WIDTH'(1));
  endfunction

  assign isolated = screening_by_junior(pending);
`endif

  // Zero or one bit left means the current beat is the word's final beat
  assign single_bit = ((pending & (pending - WORD_WIDTH'(1))) == '0);

  one_hot_encoder #(
    .WORD_WIDTH (WORD_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_one_hot_encoder (
    .one_hot(isolated),
    .index  (enc_index)
  );

  // State and pending-mask registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
    end
  end

  // Next-state logic and outputs; outputs depend only on registered state/pending
  always_comb begin
    state_next   = state;
    pending_next = pending;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_index    = '0;
    out_last     = 1'b0;
    out_empty    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_next = in_word;
          state_next   = SCAN;
        end
      end
      SCAN: begin
        out_valid = 1'b1;
        out_index = enc_index;
        out_last  = single_bit;
        out_empty = (pending == '0);
        if (out_ready) begin
          pending_next = pending & ~isolated;
          if (single_bit) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Testbench for bit_scan_encoder: table-driven words plus hand-written
// back-pressure, back-to-back and mid-scan reset sequences.
module tb_bit_scan_encoder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_word;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic       out_last;
  logic       out_empty;

  int tests;
  int fails;

  logic [2:0] exp_q[$];

  typedef struct {
    logic [7:0] word;
    int         n;
    logic [2:0] idx [8];
  } vec_t;

  vec_t vecs[6];

  bit_scan_encoder u_dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_last (out_last),
    .out_empty(out_empty)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load the scoreboard with indices given lowest-first; reverse for MSB-first build
  task automatic load_expected(input vec_t v);
    exp_q.delete();
    for (int i = 0; i < v.n; i++) begin
`ifdef BIT_SCAN_ENCODER_MSB_FIRST_EN
      exp_q.push_back(v.idx[v.n-1-i]);
`else
      exp_q.push_back(v.idx[i]);
`endif
    end
  endtask

  // Offer one word with out_ready high and check every beat on consecutive cycles.
  // Entered and left just after a falling edge.
  task automatic run_word(input logic [7:0] word);
    logic [2:0] e;
    check("idle_in_ready", 32'(in_ready), 32'd1);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    in_valid  = 1'b1;
    in_word   = word;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check("zero_valid", 32'(out_valid), 32'd1);
      check("zero_empty", 32'(out_empty), 32'd1);
      check("zero_index", 32'(out_index), 32'd0);
      check("zero_last", 32'(out_last), 32'd1);
      @(negedge clk);
    end else begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat_valid", 32'(out_valid), 32'd1);
        check("beat_index", 32'(out_index), 32'(e));
        check("beat_last", 32'(out_last), 32'(exp_q.size() == 0));
        check("beat_empty", 32'(out_empty), 32'd0);
        check("beat_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
    end
    check("after_out_valid", 32'(out_valid), 32'd0);
    check("after_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vec_t v;
    logic [2:0] e;
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;

    vecs[0].word = 8'b1010_0100; vecs[0].n = 3; vecs[0].idx = '{3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[1].word = 8'h00;        vecs[1].n = 0; vecs[1].idx = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[2].word = 8'h01;        vecs[2].n = 1; vecs[2].idx = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[3].word = 8'h80;        vecs[3].n = 1; vecs[3].idx = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[4].word = 8'b0101_1010; vecs[4].n = 4; vecs[4].idx = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0};
    vecs[5].word = 8'b0000_0110; vecs[5].n = 2; vecs[5].idx = '{3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

    // reset, then idle three cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_empty", 32'(out_empty), 32'd0);
      @(negedge clk);
    end

    // table-driven words with out_ready held high
    for (int t = 0; t < 6; t++) begin
      load_expected(vecs[t]);
      run_word(vecs[t].word);
    end

    // back-pressure: 8'h81 with out_ready low for three cycles
    v.word = 8'h81; v.n = 2; v.idx = '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    load_expected(v);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = v.word;
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) out_ready = 1'b1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_index", 32'(out_index), 32'(e));
      check("hold_last", 32'(out_last), 32'd0);
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check("hold_second_index", 32'(out_index), 32'(e));
    check("hold_second_last", 32'(out_last), 32'd1);
    @(negedge clk);
    check("hold_done_valid", 32'(out_valid), 32'd0);

    // back-to-back: 8'hFF then 8'h02 offered while busy, in_valid held high
    v.word = 8'hFF; v.n = 8; v.idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    load_expected(v);
    in_valid = 1'b1;
    in_word  = 8'hFF;
    @(negedge clk);
    in_word = 8'h02;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("b2b_index", 32'(out_index), 32'(e));
      check("b2b_last", 32'(out_last), 32'(exp_q.size() == 0));
      check("b2b_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check("b2b_gap_in_ready", 32'(in_ready), 32'd1);
    check("b2b_gap_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_next_valid", 32'(out_valid), 32'd1);
    check("b2b_next_index", 32'(out_index), 32'd1);
    check("b2b_next_last", 32'(out_last), 32'd1);
    @(negedge clk);
    check("b2b_end_valid", 32'(out_valid), 32'd0);

    // reset after the first beat of 8'b0011_0000; the second index must never appear
    v.word = 8'b0011_0000; v.n = 2; v.idx = '{3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    load_expected(v);
    in_valid = 1'b1;
    in_word  = v.word;
    @(negedge clk);
    in_valid = 1'b0;
    e = exp_q.pop_front();
    check("mid_first_index", 32'(out_index), 32'(e));
    @(negedge clk);
    e = exp_q.pop_front();
    check("mid_second_shown", 32'(out_index), 32'(e));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_index", 32'(out_index), 32'd0);
    check("mid_rst_out_last", 32'(out_last), 32'd0);
    check("mid_rst_out_empty", 32'(out_empty), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_quiet_valid", 32'(out_valid), 32'd0);
    end

    // recovery after reset
    load_expected(vecs[0]);
    run_word(vecs[0].word);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
